// File: rtl/psram_xfer_arb.sv
// psram_xfer_arb: round-robin bus/cfg arbiter and handshake sequencer for the PSRAM core transfer port
module psram_xfer_arb #(
    parameter int RECY_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [RECY_W-1:0] recy_i,
    input  logic              bus_req_i,
    input  logic              bus_rdwr_i,
    input  logic [31:0]       bus_addr_i,
    input  logic [63:0]       bus_wr_data_i,
    input  logic [7:0]        bus_wr_mask_i,
    output logic              bus_gnt_o,
    output logic              bus_done_o,
    output logic [63:0]       bus_rd_data_o,
    input  logic              cfg_req_i,
    input  logic              cfg_rdwr_i,
    input  logic [31:0]       cfg_addr_i,
    input  logic [7:0]        cfg_wr_data_i,
    output logic              cfg_gnt_o,
    output logic              cfg_done_o,
    output logic [7:0]        cfg_rd_data_o,
    output logic              xfer_valid_o,
    input  logic              xfer_ready_i,
    output logic              xfer_rdwr_o,
    output logic              xfer_cfg_o,
    output logic [31:0]       xfer_addr_o,
    output logic [63:0]       xfer_wr_data_o,
    output logic [7:0]        xfer_wr_mask_o,
    input  logic              xfer_done_i,
    input  logic [63:0]       xfer_rd_data_i,
    output logic              busy_o,
    output logic              owner_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECY} state_t;
    state_t            state, state_nxt;
    logic [RECY_W-1:0] cnt;
    logic              last_owner, go, pick_cfg, done_hit;
    always_comb begin
        pick_cfg     = cfg_req_i && (!bus_req_i || !last_owner);
        go           = state == IDLE && en_i && (bus_req_i || cfg_req_i);
        bus_gnt_o    = go && !pick_cfg;
        cfg_gnt_o    = go && pick_cfg;
        done_hit     = state == WAIT && xfer_done_i;
        xfer_valid_o = state == ISSUE;
        busy_o       = state != IDLE;
        state_nxt    = state;
        unique case (state)
            IDLE:  state_nxt = go ? ISSUE : IDLE;
            ISSUE: state_nxt = xfer_ready_i ? WAIT : ISSUE;
            WAIT:  state_nxt = xfer_done_i ? (recy_i == '0 ? IDLE : RECY) : WAIT;
            RECY:  state_nxt = cnt <= RECY_W'(1) ? IDLE : RECY;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_owner     <= 1'b1;
            owner_o        <= 1'b0;
            xfer_cfg_o     <= 1'b0;
            xfer_rdwr_o    <= 1'b0;
            xfer_addr_o    <= '0;
            xfer_wr_data_o <= '0;
            xfer_wr_mask_o <= '0;
            bus_done_o     <= 1'b0;
            cfg_done_o     <= 1'b0;
            bus_rd_data_o  <= '0;
            cfg_rd_data_o  <= '0;
            cnt            <= '0;
        end else begin
            bus_done_o <= done_hit && !owner_o;
            cfg_done_o <= done_hit && owner_o;
            if (go) begin
                last_owner     <= pick_cfg;
                owner_o        <= pick_cfg;
                xfer_cfg_o     <= pick_cfg;
                xfer_rdwr_o    <= pick_cfg ? cfg_rdwr_i : bus_rdwr_i;
                xfer_addr_o    <= pick_cfg ? cfg_addr_i : bus_addr_i;
                xfer_wr_data_o <= pick_cfg ? {56'd0, cfg_wr_data_i} : bus_wr_data_i;
                xfer_wr_mask_o <= pick_cfg ? 8'h01 : bus_wr_mask_i;
            end
            if (done_hit && xfer_rdwr_o && !owner_o) bus_rd_data_o <= xfer_rd_data_i;
            if (done_hit && xfer_rdwr_o && owner_o) cfg_rd_data_o <= xfer_rd_data_i[7:0];
            if (done_hit) cnt <= recy_i;
            else if (state == RECY) cnt <= cnt - RECY_W'(1);
        end
    end
endmodule
